// File: rtl/gray_to_binary_decoder.sv
// Synchronises a gray-coded count into the clk domain, decodes it to binary and
// classifies each change as a +1 step, a -1 step or an illegal jump.
module gray_to_binary_decoder #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             init_done,
  output logic             bin_valid,
  output logic             step_up,
  output logic             step_down,
  output logic             step_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned CNT_W = $clog2(SYNC_STAGES) + 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_g_prev, w_g_prev_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_bin, w_bin_nxt;
  logic             r_init, w_init_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_up, w_up_nxt;
  logic             r_down, w_down_nxt;
  logic             r_err, w_err_nxt;
  logic [ERR_W-1:0] r_err_cnt, w_err_cnt_nxt;

  logic [WIDTH-1:0] w_g_sync;
  logic [WIDTH-1:0] w_g_init;
  logic [WIDTH-1:0] w_bin_sync;
  logic [WIDTH-1:0] w_bin_init;
  logic [WIDTH-1:0] w_diff;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= gray_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_g_sync   = r_sync[SYNC_STAGES-1];
  // The INIT-ending edge loads the value the last stage is about to take, so
  // g_prev matches g_sync on the first RUN edge and no spurious change is seen.
  assign w_g_init   = r_sync[SYNC_STAGES-2];
  assign w_bin_sync = gray2bin(w_g_sync);
  assign w_bin_init = gray2bin(w_g_init);
  assign w_diff     = w_bin_sync - r_bin;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_INIT;
      r_g_prev  <= '0;
      r_cnt     <= '0;
      r_bin     <= '0;
      r_init    <= 1'b0;
      r_valid   <= 1'b0;
      r_up      <= 1'b0;
      r_down    <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_g_prev  <= w_g_prev_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bin     <= w_bin_nxt;
      r_init    <= w_init_nxt;
      r_valid   <= w_valid_nxt;
      r_up      <= w_up_nxt;
      r_down    <= w_down_nxt;
      r_err     <= w_err_nxt;
      r_err_cnt <= w_err_cnt_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_g_prev_nxt  = r_g_prev;
    w_cnt_nxt     = r_cnt;
    w_bin_nxt     = r_bin;
    w_init_nxt    = r_init;
    w_valid_nxt   = 1'b0;
    w_up_nxt      = 1'b0;
    w_down_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    w_err_cnt_nxt = r_err_cnt;

    case (r_state)
      ST_INIT: begin
        if (r_cnt == CNT_W'(SYNC_STAGES - 1)) begin
          w_state_nxt  = ST_RUN;
          w_bin_nxt    = w_bin_init;
          w_g_prev_nxt = w_g_init;
          w_init_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (w_g_sync != r_g_prev) begin
          w_bin_nxt    = w_bin_sync;
          w_g_prev_nxt = w_g_sync;
          w_valid_nxt  = 1'b1;
          if (w_diff == WIDTH'(1)) begin
            w_up_nxt = 1'b1;
          end else if (w_diff == '1) begin
            w_down_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
            if (r_err_cnt != '1) w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign bin_out   = r_bin;
  assign init_done = r_init;
  assign bin_valid = r_valid;
  assign step_up   = r_up;
  assign step_down = r_down;
  assign step_err  = r_err;
  assign err_count = r_err_cnt;

endmodule
